// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor controller: computes a - b - borrow_in over WIDTH
// cycles, LSB first, reusing one shared full_subtract cell.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      request; sampled only while idle
//   a, b       minuend / subtrahend, captured on accepted start
//   borrow_in  initial borrow, captured on accepted start
//   busy       high whenever the controller is not idle
//   done       one-cycle completion pulse
//   diff       registered difference of the last completed operation
//   borrow_out registered final borrow of the last completed operation

module full_subtract (
    output logic diff,
    output logic borrowOut,
    input  logic a,
    input  logic b,
    input  logic borrowIn
);

    assign diff      = a ^ b ^ borrowIn;
    assign borrowOut = (~a & b) | (~(a ^ b) & borrowIn);

endmodule

module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    // Upper WIDTH-1 bits of the result shifter; the lowest bit would only
    // ever be shifted out, so it is not stored.
    logic [WIDTH-2:0] r_sh;
    logic             brw;
    logic [CW-1:0]    cnt;

    logic             cell_diff;
    logic             cell_borrow;
    logic [WIDTH-1:0] r_next;

    full_subtract u_cell (
        .diff      (cell_diff),
        .borrowOut (cell_borrow),
        .a         (a_sh[0]),
        .b         (b_sh[0]),
        .borrowIn  (brw)
    );

    // New bit enters at the top so after WIDTH shifts bit 0 is the LSB.
    assign r_next = {cell_diff, r_sh};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            a_sh       <= '0;
            b_sh       <= '0;
            r_sh       <= '0;
            brw        <= 1'b0;
            cnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        brw   <= borrow_in;
                        cnt   <= '0;
                        r_sh  <= '0;
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_sh <= r_next[WIDTH-1:1];
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    brw  <= cell_borrow;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        diff       <= r_next;
                        borrow_out <= cell_borrow;
                        done       <= 1'b1;
                        state      <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Scoreboard bench for serial_sub_ctrl: an 8-bit and a 4-bit instance are
// checked against plain-arithmetic expectations with cycle-exact done timing.

module tb_serial_sub_ctrl;

    typedef struct {
        logic [32:0] res;
        int          at;
    } exp_t;

    logic clk;
    logic rst_n;

    logic       s8, bi8, busy8, done8, bo8;
    logic [7:0] a8, b8, d8;
    logic       s4, bi4, busy4, done4, bo4;
    logic [3:0] a4, b4, d4;

    int edge_n;
    int free_at [2];
    logic [32:0] last [2];
    exp_t q8[$];
    exp_t q4[$];
    exp_t e8, e4;
    int n8, n4;
    logic x8, x4;

    int errors;
    int checks;

    serial_sub_ctrl #(.WIDTH(8)) dut8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (s8),
        .a          (a8),
        .b          (b8),
        .borrow_in  (bi8),
        .busy       (busy8),
        .done       (done8),
        .diff       (d8),
        .borrow_out (bo8)
    );

    serial_sub_ctrl #(.WIDTH(4)) dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (s4),
        .a          (a4),
        .b          (b4),
        .borrow_in  (bi4),
        .busy       (busy4),
        .done       (done4),
        .diff       (d4),
        .borrow_out (bo4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic chk(input string nm, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h",
                     nm, edge_n, act, req);
        end
    endtask

    function automatic logic [32:0] ref_sub(input int w, input longint av,
                                            input longint bv, input longint bi);
        longint m;
        longint d;
        logic [32:0] r;
        m = longint'(1) << w;
        d = ((av - bv - bi) % m + m) % m;
        r = '0;
        r[31:0] = d[31:0];
        r[32] = (av < bv + bi);
        return r;
    endfunction

    // Drive one cycle of stimulus just after the falling edge; the next
    // rising edge has index edge_n. Acceptance is predicted from spacing.
    task automatic issue(input int which, input logic s, input int av,
                         input int bv, input int bi);
        exp_t e;
        int w;
        @(negedge clk);
        #1;
        w = (which == 0) ? 8 : 4;
        if (which == 0) begin
            s8 = s; a8 = av[7:0]; b8 = bv[7:0]; bi8 = bi[0];
        end else begin
            s4 = s; a4 = av[3:0]; b4 = bv[3:0]; bi4 = bi[0];
        end
        if (s && rst_n && edge_n >= free_at[which]) begin
            e.res = ref_sub(w, longint'(av % (1 << w)),
                            longint'(bv % (1 << w)), longint'(bi & 1));
            e.at = edge_n + w + 1;
            free_at[which] = edge_n + w + 2;
            if (which == 0) q8.push_back(e);
            else q4.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        n8 = edge_n;
        x8 = (q8.size() > 0) && (q8[0].at == n8);
        chk("busy8", busy8, n8 < free_at[0]);
        chk("done8", done8, x8);
        if (done8 && x8) begin
            e8 = q8.pop_front();
            last[0] = e8.res;
        end
        chk("diff8", d8, last[0][7:0]);
        chk("borrow8", bo8, last[0][32]);
    end

    always @(negedge clk) begin
        n4 = edge_n;
        x4 = (q4.size() > 0) && (q4[0].at == n4);
        chk("busy4", busy4, n4 < free_at[1]);
        chk("done4", done4, x4);
        if (done4 && x4) begin
            e4 = q4.pop_front();
            last[1] = e4.res;
        end
        chk("diff4", d4, last[1][3:0]);
        chk("borrow4", bo4, last[1][32]);
    end

    initial begin
        errors = 0;
        checks = 0;
        edge_n = 0;
        rst_n = 1'b0;
        free_at[0] = 0;
        free_at[1] = 0;
        last[0] = '0;
        last[1] = '0;
        s8 = 0; a8 = 0; b8 = 0; bi8 = 0;
        s4 = 0; a4 = 0; b4 = 0; bi4 = 0;
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        free_at[0] = edge_n;
        free_at[1] = edge_n;

        issue(0, 1, 'h5A, 'h3C, 0);
        repeat (11) issue(0, 0, 'h00, 'h00, 0);

        issue(0, 1, 'h00, 'h01, 0);
        repeat (10) issue(0, 0, 'hAA, 'h55, 1);
        issue(0, 1, 'h00, 'h00, 1);
        repeat (10) issue(0, 0, 'h00, 'h00, 0);

        // Re-requests during RUN (i=3) and during DONE (i=9) must be ignored.
        issue(0, 1, 'hFF, 'hFF, 0);
        for (int i = 1; i <= 10; i++)
            issue(0, (i == 3) || (i == 9), 'h01, 'h00, 0);
        repeat (3) issue(0, 0, 'h00, 'h00, 0);

        repeat (30) issue(0, 1, 'h10, 'h01, 1);
        repeat (12) issue(0, 0, 'h00, 'h00, 0);

        // Asynchronous reset in the middle of an operation.
        issue(0, 1, 'h80, 'h01, 0);
        repeat (4) issue(0, 0, 'h00, 'h00, 0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_busy", busy8, 0);
        chk("rst_diff", d8, 0);
        chk("rst_borrow", bo8, 0);
        q8.delete();
        q4.delete();
        last[0] = '0;
        last[1] = '0;
        free_at[0] = edge_n;
        free_at[1] = edge_n;
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        free_at[0] = edge_n;
        free_at[1] = edge_n;
        issue(0, 1, 'h80, 'h01, 0);
        repeat (11) issue(0, 0, 'h00, 'h00, 0);

        repeat (80)
            issue(0, $urandom_range(0, 2) == 0, int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 255)), int'($urandom_range(0, 1)));
        repeat (12) issue(0, 0, 'h00, 'h00, 0);

        for (int av = 0; av < 16; av++)
            for (int bv = 0; bv < 16; bv++)
                for (int bi = 0; bi < 2; bi++) begin
                    issue(1, 1, av, bv, bi);
                    repeat (5)
                        issue(1, 0, int'($urandom_range(0, 15)),
                              int'($urandom_range(0, 15)),
                              int'($urandom_range(0, 1)));
                end
        repeat (10) issue(1, 0, 0, 0, 0);

        chk("pending8", q8.size(), 0);
        chk("pending4", q4.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
